lsu: RTL and testbench

Load/store unit between the decode/control stage and the data memory bus. Takes the decoded memory controls (`mem_wren`, `mem_mode`, `mem_unsigned`), the ALU-computed address and the store operand, and runs one bus transaction per request. It handles byte-enable generation, store-data replication, load extraction with sign/zero extension, misalignment and timeout errors. The core is stalled until the access completes.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_if.sv | 23 ++
 rtl/lsu_align.sv | 46 ++++
 rtl/lsu.sv | 145 ++++++++++++++
 tb/tb_lsu.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store encodings, FSM state type and default bus timeout for the LSU.
package lsu_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StErr
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Data memory bus seen from the LSU: request/write channel and grant/read-return channel.
interface lsu_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store replication, misalign check and
// load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] ld_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata      = st_data;
    misaligned = 1'b0;
    ld_ext     = rdata;
    case (mode)
      MEM_BYTE: begin
        be     = 4'b0001 << addr_lo;
        wdata  = {4{st_data[7:0]}};
        ld_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{st_data[15:0]}};
        misaligned = addr_lo[0];
        ld_ext     = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      MEM_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per request, stalling the core until done or err.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_wren,
  input  logic [1:0]  mem_mode,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] ld_data,
  lsu_if.master       bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_e  state_q;
  logic [1:0]  mode_q;
  logic [1:0]  addr_lo_q;
  logic        uns_q;
  logic [CntW-1:0] cnt_q;
  logic        done_q, err_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, ld_data_q;
  logic [3:0]  bus_be_q;

  logic [1:0]  al_mode, al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;
  logic        al_mis;
  logic        timeout_hit;

  // Idle decodes the live request; afterwards the latched copy drives load extraction.
  assign al_mode = (state_q == StIdle) ? mem_mode  : mode_q;
  assign al_lo   = (state_q == StIdle) ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .mode        (al_mode),
    .addr_lo     (al_lo),
    .st_data     (st_data),
    .is_unsigned (uns_q),
    .rdata       (bus.rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .misaligned  (al_mis),
    .ld_ext      (al_ld)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= MEM_BYTE;
      addr_lo_q   <= 2'b00;
      uns_q       <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      ld_data_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mode_q    <= mem_mode;
            addr_lo_q <= addr[1:0];
            uns_q     <= mem_unsigned;
            cnt_q     <= '0;
            if (al_mis) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              state_q     <= StReq;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_wren;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= al_be;
              bus_wdata_q <= al_wdata;
            end
          end
        end
        StReq: begin
          // The counter keeps running into WAIT so the bound covers the whole access.
          cnt_q <= cnt_q + 1'b1;
          if (bus.gnt) begin
            bus_req_q <= 1'b0;
            if (bus_we_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end else if (timeout_hit) begin
            bus_req_q <= 1'b0;
            state_q   <= StErr;
            err_q     <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StWait: begin
          if (bus.rvalid) begin
            ld_data_q <= al_ld;
            state_q   <= StDone;
            done_q    <= 1'b1;
            cnt_q     <= '0;
          end else if (timeout_hit) begin
            state_q <= StErr;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall     = req_valid & ~done_q & ~err_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ld_data   = ld_data_q;
  assign bus.req   = bus_req_q;
  assign bus.we    = bus_we_q;
  assign bus.addr  = bus_addr_q;
  assign bus.be    = bus_be_q;
  assign bus.wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads with extension, bus stalls, errors, timeout, reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid_t = 1'b0;
  logic        mem_wren = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_mode = 2'b00;
  logic [31:0] addr = 32'd0, st_data = 32'd0;
  logic        stall, done, err, stall_t, done_t, err_t;
  logic [31:0] ld_data, ld_data_t;
  int          nchecks = 0;
  int          nerrors = 0;

  lsu_if bus ();
  lsu_if bus_t ();

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .mem_wren     (mem_wren),
    .mem_mode     (mem_mode),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .st_data      (st_data),
    .stall        (stall),
    .done         (done),
    .err          (err),
    .ld_data      (ld_data),
    .bus          (bus)
  );

  lsu #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid_t),
    .mem_wren     (mem_wren),
    .mem_mode     (mem_mode),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .st_data      (st_data),
    .stall        (stall_t),
    .done         (done_t),
    .err          (err_t),
    .ld_data      (ld_data_t),
    .bus          (bus_t)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0;
    bus_t.gnt = 1'b0; bus_t.rvalid = 1'b0; bus_t.rdata = 32'd0;
    #2;
    nchecks++;
    if ({bus.req, bus.we, bus.addr, bus.be, bus.wdata, done, err, ld_data, stall} !== 104'd0) begin
      nerrors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wdata=%h done=%b err=%b ld=%h stall=%b, want all 0",
               bus.req, bus.we, bus.addr, bus.be, bus.wdata, done, err, ld_data, stall);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    nchecks++;
    if (bus.req !== 1'b0 || done !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_idle: got req=%b done=%b, want 0 0", bus.req, done);
    end
  endtask

  task automatic test_store(input string name, input logic [1:0] mode, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    mem_wren = 1'b1; mem_mode = mode; addr = a; st_data = d; req_valid = 1'b1;
    step();  // cycle 1
    nchecks++;
    if (bus.req !== 1'b1 || bus.we !== 1'b1 || bus.addr !== {a[31:2], 2'b00} ||
        bus.be !== exp_be || bus.wdata !== exp_wdata || stall !== 1'b1 || done !== 1'b0) begin
      nerrors++;
      $display("FAIL %s_bus: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b done=%b, want 1 1 %h %b %h 1 0",
               name, bus.req, bus.we, bus.addr, bus.be, bus.wdata, stall, done,
               {a[31:2], 2'b00}, exp_be, exp_wdata);
    end
    bus.gnt = 1'b1;
    step();  // cycle 2
    bus.gnt = 1'b0;
    nchecks++;
    if (done !== 1'b1 || err !== 1'b0 || stall !== 1'b0 || bus.req !== 1'b0) begin
      nerrors++;
      $display("FAIL %s_done: got done=%b err=%b stall=%b req=%b, want 1 0 0 0",
               name, done, err, stall, bus.req);
    end
    req_valid = 1'b0;
    step();
    nchecks++;
    if (done !== 1'b0) begin
      nerrors++;
      $display("FAIL %s_pulse: got done=%b, want 0", name, done);
    end
  endtask

  task automatic test_load_half(input string name, input logic uns, input logic [31:0] exp);
    mem_wren = 1'b0; mem_mode = 2'b01; mem_unsigned = uns; addr = 32'h2002; req_valid = 1'b1;
    step();  // cycle 1
    nchecks++;
    if (bus.req !== 1'b1 || bus.we !== 1'b0 || bus.be !== 4'b1100 || bus.addr !== 32'h2000) begin
      nerrors++;
      $display("FAIL %s_bus: got req=%b we=%b be=%b addr=%h, want 1 0 1100 00002000",
               name, bus.req, bus.we, bus.be, bus.addr);
    end
    bus.gnt = 1'b1;
    bus.rvalid = 1'b1;  // ignored in REQ
    bus.rdata = 32'h0BAD0BAD;
    step();  // cycle 2
    bus.gnt = 1'b0;
    bus.rdata = 32'h80FF1234;
    nchecks++;
    if (done !== 1'b0 || bus.req !== 1'b0 || stall !== 1'b1) begin
      nerrors++;
      $display("FAIL %s_wait: got done=%b req=%b stall=%b, want 0 0 1", name, done, bus.req, stall);
    end
    step();  // cycle 3
    bus.rvalid = 1'b0;
    nchecks++;
    if (done !== 1'b1 || ld_data !== exp) begin
      nerrors++;
      $display("FAIL %s_data: got done=%b ld=%h, want 1 %h", name, done, ld_data, exp);
    end
    req_valid = 1'b0;
    mem_unsigned = 1'b0;
    step();
  endtask

  task automatic test_lw_stalls();
    int ndone = 0;
    mem_wren = 1'b0; mem_mode = 2'b10; addr = 32'h4000; req_valid = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      bus.gnt = 1'b0;
      bus.rvalid = 1'b0;
      if (done === 1'b1) ndone++;
      nchecks++;
      if (stall !== (cyc < 7) || done !== (cyc == 7)) begin
        nerrors++;
        $display("FAIL lw_stall_c%0d: got stall=%b done=%b, want %b %b",
                 cyc, stall, done, cyc < 7, cyc == 7);
      end
      if (cyc == 7) begin
        nchecks++;
        if (ld_data !== 32'hDEADBEEF) begin
          nerrors++;
          $display("FAIL lw_data: got %h, want deadbeef", ld_data);
        end
        req_valid = 1'b0;
      end
      if (cyc == 4) bus.gnt = 1'b1;
      if (cyc == 6) begin
        bus.rvalid = 1'b1;
        bus.rdata = 32'hDEADBEEF;
      end
    end
    nchecks++;
    if (ndone != 1) begin
      nerrors++;
      $display("FAIL lw_done_count: got %0d pulses, want 1", ndone);
    end
  endtask

  task automatic test_error(input string name, input logic [1:0] mode, input logic [31:0] a);
    int nreq = 0;
    mem_wren = 1'b0; mem_mode = mode; addr = a; req_valid = 1'b1;
    step();  // cycle 1
    if (bus.req === 1'b1) nreq++;
    nchecks++;
    if (err !== 1'b1 || done !== 1'b0 || stall !== 1'b0) begin
      nerrors++;
      $display("FAIL %s_err: got err=%b done=%b stall=%b, want 1 0 0", name, err, done, stall);
    end
    req_valid = 1'b0;
    step();
    if (bus.req === 1'b1) nreq++;
    nchecks++;
    if (err !== 1'b0 || nreq != 0 || ld_data !== 32'hDEADBEEF) begin
      nerrors++;
      $display("FAIL %s_after: got err=%b req_cycles=%0d ld=%h, want 0 0 deadbeef",
               name, err, nreq, ld_data);
    end
  endtask

  task automatic test_timeout();
    mem_wren = 1'b0; mem_mode = 2'b10; addr = 32'h5000; req_valid_t = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      nchecks++;
      if (bus_t.req !== 1'b1 || err_t !== 1'b0 || stall_t !== 1'b1) begin
        nerrors++;
        $display("FAIL timeout_req_c%0d: got req=%b err=%b stall=%b, want 1 0 1",
                 cyc, bus_t.req, err_t, stall_t);
      end
    end
    step();  // cycle 5
    nchecks++;
    if (err_t !== 1'b1 || bus_t.req !== 1'b0 || done_t !== 1'b0) begin
      nerrors++;
      $display("FAIL timeout_err: got err=%b req=%b done=%b, want 1 0 0", err_t, bus_t.req, done_t);
    end
    req_valid_t = 1'b0;
    step();
  endtask

  task automatic test_reset_wait();
    mem_wren = 1'b0; mem_mode = 2'b10; addr = 32'h6000; req_valid = 1'b1;
    step();  // cycle 1
    bus.gnt = 1'b1;
    step();  // cycle 2: WAIT
    bus.gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    nchecks++;
    if ({bus.req, bus.we, bus.addr, bus.be, bus.wdata, done, err, ld_data} !== 103'd0) begin
      nerrors++;
      $display("FAIL rst_wait_outputs: got req=%b we=%b addr=%h be=%b wdata=%h done=%b err=%b ld=%h, want all 0",
               bus.req, bus.we, bus.addr, bus.be, bus.wdata, done, err, ld_data);
    end
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata = 32'h12345678;
    step();
    bus.rvalid = 1'b0;
    step();
    nchecks++;
    if (done !== 1'b0 || err !== 1'b0 || ld_data !== 32'd0 || bus.req !== 1'b0) begin
      nerrors++;
      $display("FAIL rst_wait_late_rvalid: got done=%b err=%b ld=%h req=%b, want 0 0 0 0",
               done, err, ld_data, bus.req);
    end
  endtask

  initial begin
    test_reset();
    test_store("sb", 2'b00, 32'h1003, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    test_store("sh", 2'b01, 32'h1002, 32'h12345678, 4'b1100, 32'h56785678);
    test_store("sw", 2'b10, 32'h1004, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    test_load_half("lh", 1'b0, 32'hFFFF80FF);
    test_load_half("lhu", 1'b1, 32'h000080FF);
    test_lw_stalls();
    test_error("lw_misaligned", 2'b10, 32'h3001);
    test_error("mode_illegal", 2'b11, 32'h3000);
    test_timeout();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
